std_fifo: RTL and testbench
===========================

Name: std_fifo

Overview:
- Single-clock synchronous FIFO with registered read data, an occupancy count, and full/empty/almost-full/almost-empty status flags.
- General-purpose buffering primitive between a producer (push/d) and a consumer (pop/q) in the same clock domain.
- Storage is a circular buffer indexed by read and write pointers.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 64, number of entries; must be a power of two, at least 4.
- COUNT_WIDTH, 7, width of count; must equal log2(DEPTH)+1 so it can hold 0..DEPTH.
- ALMOST_EMPTY_THRESH, 2, almost_empty is asserted when count <= this value.
- ALMOST_FULL_THRESH, 62, almost_full is asserted when count >= this value.

Ports:
- rst  input  1  reset; asynchronous, active-low (0 = reset).
- clk  input  1  clock; all state updates on the rising edge.
- push  input  1  write request; d is written on the rising edge if accepted.
- pop  input  1  read request; the head entry is loaded into q on the rising edge if accepted.
- d  input  WIDTH  write data.
- q  output  WIDTH  read data register.
- full  output  1  high when count == DEPTH.
- empty  output  1  high when count == 0.
- count  output  COUNT_WIDTH  number of stored entries.
- almost_empty  output  1  high when count <= ALMOST_EMPTY_THRESH.
- almost_full  output  1  high when count >= ALMOST_FULL_THRESH.

Behaviour:
- Reset, asynchronous on rst=0:
  - Write pointer, read pointer and count clear to 0; q clears to 0.
  - Outputs during and after reset: empty=1, full=0, almost_empty=1, almost_full=0.
  - Storage array contents are not reset.
  - Reset asserted mid-operation discards all contents immediately.
- Flags are decoded combinationally from the registered count, so they reflect the post-edge state in the same cycle count changes. No glitch paths from push/pop to the flags.
- Accepted pop: pop_ok = pop & ~empty.
  - q <= mem[rd_ptr]; rd_ptr increments.
  - Data is visible on q after that rising edge (one-cycle read latency).
  - q holds its value when no pop is accepted.
- Accepted push: push_ok = push & (~full | pop_ok).
  - mem[wr_ptr] <= d; wr_ptr increments.
  - A push while full is accepted only if a pop is accepted in the same cycle.
- Pop while empty is ignored: no pointer change and q unchanged, including when push is high in the same cycle. That pushed word is written, count becomes 1, and it is not bypassed to q.
- Count update: +1 on push_ok only, -1 on pop_ok only, unchanged when both or neither.
- Pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0 naturally.
- Overflow or underflow can never corrupt count or pointers.
- Ordering is strict first-in, first-out.

Test Plan:
- Reset: hold rst=0 for 10 cycles, release -> empty=1, full=0, count=0, almost_empty=1, almost_full=0, q=0.
- Fill: push values 1..64 on consecutive cycles -> empty=0 after the first edge; full=0 through 63 entries; full=1 and count=64 after the 64th; almost_full=1 from count 62.
- Overflow: with the FIFO full, push=1 for 3 cycles with d=0xAA -> count stays 64 and 0xAA is never read back.
- Drain: pop=1 for 64 cycles -> q reads 1,2,...,64 in order, one per cycle after each edge. Afterwards empty=1, full=0, count=0, and q holds 64. An extra pop leaves q=64.
- Simultaneous: with 5 entries, push and pop together for 100 cycles with an incrementing d -> count stays 5, data order is preserved, and pointers wrap past 63 without error. With the FIFO full, push+pop -> count stays 64 and the new word is stored. With the FIFO empty, push+pop -> count=1 and q is unchanged.
- Async reset mid-stream: assert rst=0 between clock edges while holding 30 entries -> empty=1, count=0, q=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/std_fifo.sv
// Single-clock FIFO: circular buffer with registered read data, occupancy count
// and status flags decoded from the registered count.
module std_fifo #(
    parameter int WIDTH               = 8,
    parameter int DEPTH               = 64,
    parameter int COUNT_WIDTH         = 7,
    parameter int ALMOST_EMPTY_THRESH = 2,
    parameter int ALMOST_FULL_THRESH  = 62
) (
    input  logic                   rst,
    input  logic                   clk,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       d,
    output logic [WIDTH-1:0]       q,
    output logic                   full,
    output logic                   empty,
    output logic [COUNT_WIDTH-1:0] count,
    output logic                   almost_empty,
    output logic                   almost_full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign pop_ok  = pop & ~empty;
    // A push into a full FIFO only fits if a pop frees a slot on the same edge.
    assign push_ok = push & (~full | pop_ok);

    assign empty        = (count == '0);
    assign full         = (count == COUNT_WIDTH'(DEPTH));
    assign almost_empty = (count <= COUNT_WIDTH'(ALMOST_EMPTY_THRESH));
    assign almost_full  = (count >= COUNT_WIDTH'(ALMOST_FULL_THRESH));

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            q      <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                q      <= mem[rd_ptr];
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + COUNT_WIDTH'(1);
                2'b01:   count <= count - COUNT_WIDTH'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_std_fifo.sv
// Directed bench for std_fifo: a vector table for the basic push/pop cases and
// hand-written sequences for fill, overflow, drain, wrap and async reset.
module tb_std_fifo;

    logic       rst;
    logic       clk;
    logic       push;
    logic       pop;
    logic [7:0] d;
    logic [7:0] q;
    logic       full;
    logic       empty;
    logic [6:0] count;
    logic       almost_empty;
    logic       almost_full;

    int total = 0;
    int bad   = 0;

    std_fifo #(
        .WIDTH(8), .DEPTH(64), .COUNT_WIDTH(7),
        .ALMOST_EMPTY_THRESH(2), .ALMOST_FULL_THRESH(62)
    ) dut (
        .rst(rst), .clk(clk), .push(push), .pop(pop), .d(d), .q(q),
        .full(full), .empty(empty), .count(count),
        .almost_empty(almost_empty), .almost_full(almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       push;
        logic       pop;
        logic [7:0] d;
        logic [7:0] q;
        int         cnt;
        logic       empty;
        logic       full;
        logic       ae;
        logic       af;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Flags follow from the expected count by their definitions.
    task automatic chk_state(input string tag, input int exp_q, input int exp_cnt);
        chk({tag, " q"}, int'(q), exp_q);
        chk({tag, " count"}, int'(count), exp_cnt);
        chk({tag, " empty"}, int'(empty), int'(exp_cnt == 0));
        chk({tag, " full"}, int'(full), int'(exp_cnt == 64));
        chk({tag, " almost_empty"}, int'(almost_empty), int'(exp_cnt <= 2));
        chk({tag, " almost_full"}, int'(almost_full), int'(exp_cnt >= 62));
    endtask

    task automatic step(input logic pu, input logic po, input logic [7:0] dd);
        push = pu;
        pop  = po;
        d    = dd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] v;
        logic [7:0] e;

        // push pop d    q     cnt empty full ae af
        vecs[0] = '{1'b0, 1'b1, 8'h00, 8'h00, 0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 8'h11, 8'h00, 1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 8'h22, 8'h00, 2, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 8'h33, 8'h00, 3, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 8'h00, 8'h11, 2, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 8'h44, 8'h22, 2, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 8'h00, 8'h33, 1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{1'b0, 1'b1, 8'h00, 8'h44, 0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 8'h00, 8'h44, 0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[9] = '{1'b0, 1'b0, 8'h00, 8'h44, 0, 1'b1, 1'b0, 1'b1, 1'b0};

        rst  = 1'b0;
        push = 1'b0;
        pop  = 1'b0;
        d    = 8'h00;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_state("reset", 0, 0);

        for (int i = 0; i < 10; i++) begin
            step(vecs[i].push, vecs[i].pop, vecs[i].d);
            chk($sformatf("vec%0d q", i), int'(q), int'(vecs[i].q));
            chk($sformatf("vec%0d count", i), int'(count), vecs[i].cnt);
            chk($sformatf("vec%0d empty", i), int'(empty), int'(vecs[i].empty));
            chk($sformatf("vec%0d full", i), int'(full), int'(vecs[i].full));
            chk($sformatf("vec%0d almost_empty", i), int'(almost_empty), int'(vecs[i].ae));
            chk($sformatf("vec%0d almost_full", i), int'(almost_full), int'(vecs[i].af));
        end

        // Fill with 1..64; q still holds 0x44 from the table phase.
        for (int k = 1; k <= 64; k++) begin
            step(1'b1, 1'b0, 8'(k));
            chk_state($sformatf("fill%0d", k), 'h44, k);
        end

        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 8'hAA);
            chk_state($sformatf("overflow%0d", k), 'h44, 64);
        end

        // Drain must return exactly 1..64, so 0xAA was never stored.
        for (int k = 1; k <= 64; k++) begin
            step(1'b0, 1'b1, 8'h00);
            chk_state($sformatf("drain%0d", k), k, 64 - k);
        end
        step(1'b0, 1'b1, 8'h00);
        chk_state("extra_pop", 64, 0);

        // Steady state at 5 entries, 100 push+pop cycles wrap the pointers.
        v = 8'h10;
        e = 8'h10;
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0, v);
            v++;
        end
        chk_state("sim_prefill", 64, 5);
        for (int k = 0; k < 100; k++) begin
            step(1'b1, 1'b1, v);
            v++;
            chk_state($sformatf("sim%0d", k), int'(e), 5);
            e++;
        end
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, 8'h00);
            chk_state($sformatf("sim_drain%0d", k), int'(e), 4 - k);
            e++;
        end

        // Full FIFO: push+pop keeps count at 64 and stores the new word.
        for (int k = 0; k < 64; k++) begin
            step(1'b1, 1'b0, 8'(8'h80 + k));
        end
        chk_state("refill", int'(e) - 1, 64);
        step(1'b1, 1'b1, 8'h55);
        chk_state("full_pushpop", 'h80, 64);
        for (int k = 1; k < 64; k++) begin
            step(1'b0, 1'b1, 8'h00);
            chk_state($sformatf("full_drain%0d", k), 'h80 + k, 64 - k);
        end
        step(1'b0, 1'b1, 8'h00);
        chk_state("full_drain_last", 'h55, 0);

        // Empty FIFO: push+pop writes the word, no bypass to q.
        step(1'b1, 1'b1, 8'h66);
        chk_state("empty_pushpop", 'h55, 1);
        step(1'b0, 1'b1, 8'h00);
        chk_state("empty_pushpop_read", 'h66, 0);

        // Async reset between edges with 30 entries held.
        for (int k = 0; k < 30; k++) begin
            step(1'b1, 1'b0, 8'(8'hC0 + k));
        end
        chk_state("pre_reset", 'h66, 30);
        push = 1'b0;
        pop  = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk_state("async_reset", 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_state("after_reset", 0, 0);
        step(1'b1, 1'b0, 8'h77);
        chk_state("post_reset_push", 0, 1);
        step(1'b0, 1'b1, 8'h00);
        chk_state("post_reset_pop", 'h77, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
